// File: rtl/serial_adder_nbit_if.sv
// ============================================================================
//  Module      : serial_adder_nbit_if
//  Description : Handshake and operand/result bundle for serial_adder_nbit.
//                master : requester (drives start/a/b/cin, reads results)
//                slave  : adder     (reads start/a/b/cin, drives results)
//  Signals     : start, a[WIDTH], b[WIDTH], cin      requester -> adder
//                busy, done, sum[WIDTH], carry_out    adder -> requester
//                overflow                             only with ADDER_OVF_EN
//  Config      : `define ADDER_OVF_EN adds the overflow signal.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_adder_nbit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef ADDER_OVF_EN
    logic             overflow;

    modport master (output start, a, b, cin,
                    input  busy, done, sum, carry_out, overflow);
    modport slave  (input  start, a, b, cin,
                    output busy, done, sum, carry_out, overflow);
`else
    modport master (output start, a, b, cin,
                    input  busy, done, sum, carry_out);
    modport slave  (input  start, a, b, cin,
                    output busy, done, sum, carry_out);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder_nbit.sv
// ============================================================================
//  Module      : serial_adder_nbit
//  Description : Multi-cycle WIDTH-bit adder computing a + b + cin, DIGIT bits
//                per clock, least-significant digit first. Only DIGIT chained
//                full-adder cells exist; the carry is kept in a register
//                between digits. N = WIDTH/DIGIT edges per add.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    serial_adder_nbit_if.slave
//                       start/a/b/cin in; busy/done/sum/carry_out out
//                       (+ overflow with ADDER_OVF_EN)
//  Parameters  : WIDTH operand width (multiple of DIGIT), DIGIT bits per cycle
//  Config      : `define ADDER_OVF_EN adds a registered signed-overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_adder_nbit_if.slave bus
);

    localparam int c_N  = WIDTH / DIGIT;
    localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [c_CW-1:0]  r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT-1:0] w_ds;
    logic [DIGIT:0]   w_c;

    // Operands are only taken when not mid-add; a start during RUN is dropped.
    assign w_accept = bus.start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // Digit cell: DIGIT chained full adders on the low bits of the
    // shifting operand registers, carry-in from the carry register.
    // ------------------------------------------------------------------
    assign w_c[0] = r_carry;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign w_ds[gi]   = r_a[gi] ^ r_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (r_cnt == c_LAST) w_next = S_DONE;
            S_DONE:  if (bus.start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operands shift right one digit per RUN edge while result
    // digits enter the sum register from the top, so after N edges the
    // sum register holds the full result in natural order.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_c[DIGIT];
            r_sum   <= (r_sum >> DIGIT) | (WIDTH'(w_ds) << (WIDTH - DIGIT));
            // Counter parks on the last digit rather than wrapping.
            if (!w_last) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

`ifdef ADDER_OVF_EN
    logic r_ovf;

    // On the last digit, w_c[DIGIT-1] is the carry into bit WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_c[DIGIT] ^ w_c[DIGIT-1];
        end
    end

    assign bus.overflow = r_ovf;
`endif

    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_nbit.sv
// ============================================================================
//  Module      : tb_serial_adder_nbit
//  Description : Self-checking bench. Three adders (DIGIT = 2, 1, 8 with
//                WIDTH = 8) share one stimulus stream and are compared every
//                cycle against a transaction-level timing/arithmetic model,
//                plus hand-computed literal results.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_nbit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder_nbit_if #(.WIDTH(8)) if0 ();
    serial_adder_nbit_if #(.WIDTH(8)) if1 ();
    serial_adder_nbit_if #(.WIDTH(8)) if2 ();

    assign if0.start = start; assign if0.a = a; assign if0.b = b; assign if0.cin = cin;
    assign if1.start = start; assign if1.a = a; assign if1.b = b; assign if1.cin = cin;
    assign if2.start = start; assign if2.a = a; assign if2.b = b; assign if2.cin = cin;

    serial_adder_nbit #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if0));
    serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_adder_nbit #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [2:0] d_busy, d_done, d_cout, d_ovf;
    logic [7:0] d_sum [3];
    assign d_busy = {if2.busy, if1.busy, if0.busy};
    assign d_done = {if2.done, if1.done, if0.done};
    assign d_cout = {if2.carry_out, if1.carry_out, if0.carry_out};
    assign d_sum[0] = if0.sum;
    assign d_sum[1] = if1.sum;
    assign d_sum[2] = if2.sum;
`ifdef ADDER_OVF_EN
    assign d_ovf = {if2.overflow, if1.overflow, if0.overflow};
`else
    assign d_ovf = 3'b000;
`endif

    int nlat [3] = '{4, 8, 1};

    // ------------------------------------------------------------------
    // Model: an accepted request produces its result exactly N edges later;
    // results are plain integer arithmetic.
    // ------------------------------------------------------------------
    function automatic logic sovf(logic [7:0] x, logic [7:0] y, logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    logic       m_busy [3] = '{0, 0, 0};
    logic       m_done [3] = '{0, 0, 0};
    logic       m_cout [3] = '{0, 0, 0};
    logic       m_ovf  [3] = '{0, 0, 0};
    logic       m_povf [3] = '{0, 0, 0};
    logic [7:0] m_sum  [3] = '{0, 0, 0};
    logic [8:0] m_pend [3] = '{0, 0, 0};
    int         m_cnt  [3] = '{0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 0; m_done[i] <= 0; m_cout[i] <= 0;
                m_ovf[i]  <= 0; m_sum[i]  <= 0; m_cnt[i]  <= 0;
            end else if (m_busy[i]) begin
                if (m_cnt[i] + 1 == nlat[i]) begin
                    m_busy[i] <= 0;
                    m_done[i] <= 1;
                    m_sum[i]  <= m_pend[i][7:0];
                    m_cout[i] <= m_pend[i][8];
                    m_ovf[i]  <= m_povf[i];
                end
                m_cnt[i] <= m_cnt[i] + 1;
            end else if (start) begin
                m_busy[i] <= 1;
                m_done[i] <= 0;
                m_cnt[i]  <= 0;
                m_ovf[i]  <= 0;
                m_pend[i] <= 9'(a) + 9'(b) + 9'(cin);
                m_povf[i] <= sovf(a, b, cin);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=done at %0t", nm, $time);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy[%0d]", i), 32'(d_busy[i]), 32'(m_busy[i]));
            chk($sformatf("done[%0d]", i), 32'(d_done[i]), 32'(m_done[i]));
            if (m_done[i]) begin
                chk($sformatf("sum[%0d]", i),  32'(d_sum[i]),  32'(m_sum[i]));
                chk($sformatf("cout[%0d]", i), 32'(d_cout[i]), 32'(m_cout[i]));
`ifdef ADDER_OVF_EN
                chk($sformatf("ovf[%0d]", i),  32'(d_ovf[i]),  32'(m_ovf[i]));
`endif
            end
        end
    end

    // One request from an all-idle/done state; checks latency per instance.
    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc);
        bit seen [3];
        seen = '{0, 0, 0};
        @(negedge clk);
        a = xa; b = xb; cin = xc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && d_done[i]) begin
                    seen[i] = 1;
                    chk($sformatf("latency[%0d]", i), 32'(cyc), 32'(nlat[i]));
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++)
            if (!seen[i]) fail_now($sformatf("op_timeout[%0d]", i));
    endtask

    task automatic wait_all_done();
        int n;
        n = 0;
        while (d_done != 3'b111 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (d_done != 3'b111) fail_now("wait_all_done");
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(d_busy), 32'h0);
        chk("reset_done", 32'(d_done), 32'h0);
        chk("reset_sum0", 32'(if0.sum), 32'h0);
        chk("reset_cout", 32'(d_cout), 32'h0);
        chk("reset_ovf",  32'(d_ovf),  32'h0);
        rst_n = 1'b1;

        // Directed results
        do_op(8'hFF, 8'h01, 1'b0);
        chk("t1_sum", 32'(if0.sum), 32'h00);
        chk("t1_cout", 32'(if0.carry_out), 32'h1);
`ifdef ADDER_OVF_EN
        chk("t1_ovf", 32'(if0.overflow), 32'h0);
`endif
        do_op(8'h7F, 8'h01, 1'b0);
        chk("t2_sum", 32'(if0.sum), 32'h80);
        chk("t2_cout", 32'(if0.carry_out), 32'h0);
`ifdef ADDER_OVF_EN
        chk("t2_ovf", 32'(if0.overflow), 32'h1);
`endif
        do_op(8'hAA, 8'h55, 1'b1);
        chk("aa55_sum", 32'(if1.sum), 32'h00);
        chk("aa55_cout", 32'(if2.carry_out), 32'h1);
        do_op(8'h80, 8'h80, 1'b0);
        chk("8080_sum", 32'(if2.sum), 32'h00);
        chk("8080_cout", 32'(if0.carry_out), 32'h1);
`ifdef ADDER_OVF_EN
        chk("8080_ovf", 32'(if1.overflow), 32'h1);
`endif
        do_op(8'h00, 8'h00, 1'b0);
        chk("zero_sum", 32'(if0.sum), 32'h00);
        chk("zero_cout", 32'(if0.carry_out), 32'h0);

        // Start while busy is ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 8'hFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_all_done();
        chk("t3_sum_d2", 32'(if0.sum), 32'h47);
        chk("t3_cout_d2", 32'(if0.carry_out), 32'h0);
        chk("t3_sum_d1", 32'(if1.sum), 32'h47);

        // Reset mid-run
        @(negedge clk);
        a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_busy", 32'(if0.busy), 32'h0);
        chk("t4_done", 32'(if0.done), 32'h0);
        chk("t4_sum",  32'(if0.sum),  32'h0);
        chk("t4_cout", 32'(if0.carry_out), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        do_op(8'h55, 8'h22, 1'b0);
        chk("t4_fresh_sum", 32'(if0.sum), 32'h77);

        // Back-to-back with start held high
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        n = 0;
        @(negedge clk);
        while (!if0.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!if0.done) fail_now("t5_first_done");
        chk("t5_first_sum", 32'(if0.sum), 32'h30);
        a = 8'h03; b = 8'h04; cin = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!if0.done && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("t5_done_low_edges", 32'(n), 32'd4);
        chk("t5_second_sum", 32'(if0.sum), 32'h08);
        wait_all_done();

        // Random sweep across all three digit widths
        for (int k = 0; k < 1000; k++) begin
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
